// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder:
// controller state encodings and the width of the single adder slice.
package cla_seq_adder_pkg;

  // Controller states: waiting, stepping through nibbles, result pulse
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Bits handled by the lookahead slice per RUN cycle
  localparam int SLICE_W = 4;

endpackage : cla_seq_adder_pkg

// File: rtl/cla_seq_adder_cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// Every carry is formed directly from the generate/propagate terms and the
// slice carry-in, so no carry ripples between bit positions. c3 is the carry
// into bit 3, which the top level needs to derive signed overflow.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Per-bit generate, propagate and sum gates
  for (genvar i = 0; i < 4; i++) begin : g_bit
    and u_gen  (g[i], a[i], b[i]);
    xor u_prop (p[i], a[i], b[i]);
    xor u_sum  (s[i], p[i], c[i]);
  end

  // Lookahead carries, each a flat sum of products over g/p and ci
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign c3   = c[3];

endmodule : cla4_slice

// File: rtl/cla_seq_adder.sv
// Sequential WIDTH-bit adder that reuses one 4-bit lookahead slice, one
// nibble per cycle, LSB nibble first. Operands are captured on an accepted
// start, the carry is threaded between passes through a register, and the
// final pass also produces carry-out and signed overflow.
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] aReg_q, aReg_d;
  logic [WIDTH-1:0] bReg_q, bReg_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic [SLICE_W-1:0] sliceA;
  logic [SLICE_W-1:0] sliceB;
  logic [SLICE_W-1:0] sliceS;
  logic               sliceC3;
  logic               sliceCo;

  assign sliceA = aReg_q[SLICE_W*idx_q +: SLICE_W];
  assign sliceB = bReg_q[SLICE_W*idx_q +: SLICE_W];

  cla4_slice u_slice (
    .a  (sliceA),
    .b  (sliceB),
    .ci (carry_q),
    .s  (sliceS),
    .c3 (sliceC3),
    .co (sliceCo)
  );

  // Controller next state: accept work in IDLE/DONE, step nibbles in RUN
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    aReg_d  = aReg_q;
    bReg_d  = bReg_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          aReg_d  = a;
          bReg_d  = b;
          carry_d = ci;
          idx_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d[SLICE_W*idx_q +: SLICE_W] = sliceS;
        carry_d = sliceCo;
        if (idx_q == LAST_IDX) begin
          co_d    = sliceCo;
          ovf_d   = sliceC3 ^ sliceCo;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; reset discards any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      aReg_q  <= '0;
      bReg_q  <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      aReg_q  <= aReg_d;
      bReg_q  <= bReg_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule : cla_seq_adder

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; integer multiple of 4, minimum 4.
REQ-002 Derived constant: NSLICE = WIDTH/4, number of nibble passes per operation.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset, asynchronous and active-high.
REQ-005 start  in  1  request pulse; sampled only in IDLE or DONE.
REQ-006 a  in  WIDTH  operand A; captured on an accepted start.
REQ-007 b  in  WIDTH  operand B; captured on an accepted start.
REQ-008 ci  in  1  carry-in; captured on an accepted start.
REQ-009 busy  out  1  high in RUN.
REQ-010 done  out  1  one-cycle pulse; result valid.
REQ-011 s  out  WIDTH  sum register.
REQ-012 co  out  1  carry-out of the MSB.
REQ-013 ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL latch a, b and ci into operand/carry registers, clear slice index idx to 0, and enter RUN.
REQ-016 In RUN, each cycle SHALL apply nibble idx of A, nibble idx of B and the carry register to the single 4-bit CLA slice.
REQ-017 The slice sum nibble SHALL be written to s[4*idx+3:4*idx]; the slice co SHALL be written to the carry register; idx SHALL increment.
REQ-018 When idx = NSLICE-1, RUN SHALL capture co and ovf (using the slice c3 and co) and transition to DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 start=1 in DONE SHALL be accepted exactly as in IDLE (back-to-back operation, no IDLE bubble).
REQ-021 start in RUN SHALL be ignored; operand registers SHALL NOT change during RUN.
REQ-022 Latency: for start sampled at edge k, done SHALL be high in the cycle after edge k+NSLICE, giving NSLICE+1 cycles start-to-done.
REQ-023 Throughput: one result per NSLICE+1 cycles.
REQ-024 s, co and ovf SHALL hold their last result until the next accepted start and its RUN writes; nibbles not yet written in RUN SHALL hold prior values.
REQ-025 Arithmetic: {co,s} = a + b + ci, unsigned, modulo 2^(WIDTH+1); no truncation of carry.
REQ-026 For WIDTH=4, NSLICE=1: RUN SHALL be one cycle, and ovf SHALL use that slice's c3/co.

Reset
REQ-027 Asserting reset at any time, including mid-RUN, SHALL immediately force: state=IDLE, idx=0, carry register=0, operand registers=0, s=0, co=0, ovf=0, busy=0, done=0.
REQ-028 An operation interrupted by reset SHALL be discarded; no done pulse SHALL follow.
REQ-029 After reset deasserts, the first rising edge with start=1 SHALL be accepted.

Structure
REQ-030 A shared package/header SHALL hold the FSM state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the slice width constant 4.
REQ-031 The block SHALL instantiate exactly one sub-module, cla4_slice, a purely combinational 4-bit carry-lookahead adder.
REQ-032 cla4_slice ports SHALL be: a[3:0], b[3:0], ci, s[3:0], c3, co.
REQ-033 cla4_slice SHALL be built from generate/propagate terms using the team gate primitives.
REQ-034 The controller (FSM, idx counter, carry register, result register) SHALL be the only sequential logic.

Verification (WIDTH=16)
REQ-035 a=0x0001, b=0xFFFF, ci=0, start pulse -> done exactly 5 cycles after start edge, s=0x0000, co=1, ovf=0; busy high for 4 cycles.
REQ-036 a=0x7FFF, b=0x0001, ci=0 -> s=0x8000, co=0, ovf=1; then a=0x1234, b=0x4321, ci=1 -> s=0x5556, co=0, ovf=0.
REQ-037 start re-pulsed with a=0xFFFF during RUN of 0x0003+0x0004 -> ignored; s=0x0007, single done pulse.
REQ-038 start held high in DONE cycle with new operands 0x00FF+0x0001 -> immediate RUN, next done 5 cycles later, s=0x0100; no IDLE cycle between operations.
REQ-039 reset asserted asynchronously in RUN cycle 2 -> all outputs 0 within the same cycle, no done pulse; next start 0x0002+0x0002 -> s=0x0004.
REQ-040 Random regression: 1000 random a, b, ci -> {co,s} matches reference sum and ovf matches the signed rule on every done.
